// File: rtl/acc_writeback.sv
// acc_writeback
// Drains finished result rows from the accumulator into the unified buffer.
// A drain reads num_rows consecutive accumulator rows starting at acc_base,
// applies an optional per-lane ReLU and streams each row to the unified
// buffer through a valid/ready handshake. A 2-entry FIFO absorbs unified
// buffer backpressure, and read issue is throttled so that no row is lost.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                launch a drain (sampled only in IDLE)
//   acc_base, num_rows,
//   ub_base, relu_en     drain configuration, latched at start
//   busy, done           drain in progress / one-cycle completion pulse
//   acc_enb, acc_addrb   accumulator read port (1-cycle read latency)
//   acc_doutb            accumulator read data
//   ub_wea, ub_ready     unified buffer write valid / accept
//   ub_addra, ub_dina    unified buffer write address / data
module acc_writeback #(
    parameter int DATA_NUM       = 16,
    parameter int DATA_SIZE      = 8,
    parameter int ACC_ADDR_WIDTH = 4,
    parameter int UB_ADDR_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ACC_ADDR_WIDTH-1:0]     acc_base,
    input  logic [ACC_ADDR_WIDTH:0]       num_rows,
    input  logic [UB_ADDR_WIDTH-1:0]      ub_base,
    input  logic                          relu_en,
    output logic                          busy,
    output logic                          done,
    output logic                          acc_enb,
    output logic [ACC_ADDR_WIDTH-1:0]     acc_addrb,
    input  logic [DATA_NUM*DATA_SIZE-1:0] acc_doutb,
    output logic                          ub_wea,
    input  logic                          ub_ready,
    output logic [UB_ADDR_WIDTH-1:0]      ub_addra,
    output logic [DATA_NUM*DATA_SIZE-1:0] ub_dina
);

    localparam int ROW_W = DATA_NUM * DATA_SIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ACC_ADDR_WIDTH-1:0] acc_base_q;
    logic [ACC_ADDR_WIDTH:0]   num_q;
    logic [UB_ADDR_WIDTH-1:0]  ub_base_q;
    logic                      relu_q;
    logic [ACC_ADDR_WIDTH:0]   issued_q;
    logic [ACC_ADDR_WIDTH:0]   sent_q;
    logic [ACC_ADDR_WIDTH:0]   issued_inc;
    logic [ACC_ADDR_WIDTH:0]   sent_inc;
    logic                      inflight_q;

    logic [ROW_W-1:0] fifo_mem [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    logic             push;
    logic             pop;
    logic [2:0]       occ_after;
    logic [ROW_W-1:0] push_row;

    assign issued_inc = issued_q + 1'b1;
    assign sent_inc   = sent_q + 1'b1;

    // Data returns one cycle after the read, so the in-flight flag is the push.
    assign push   = inflight_q;
    assign ub_wea = (count_q != 2'd0);
    assign pop    = ub_wea && ub_ready;

    // Occupancy after this cycle's pop, counting the row still in flight.
    // Issuing only while this is below 2 guarantees every returning row has
    // a free FIFO slot, so the accumulator never needs to be stalled.
    assign occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign acc_enb   = (state_q == S_RUN) && (issued_q < num_q) && (occ_after < 3'd2);
    assign acc_addrb = (state_q == S_RUN) ? acc_base_q + issued_q[ACC_ADDR_WIDTH-1:0] : '0;

    assign ub_addra = ub_base_q + UB_ADDR_WIDTH'(sent_q);
    assign ub_dina  = ub_wea ? fifo_mem[rd_ptr_q] : '0;

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    // ReLU at push time: negative lanes are zeroed, others pass through.
    always_comb begin
        push_row = acc_doutb;
        for (int i = 0; i < DATA_NUM; i++) begin
            if (relu_q && acc_doutb[i*DATA_SIZE + DATA_SIZE - 1]) begin
                push_row[i*DATA_SIZE +: DATA_SIZE] = '0;
            end
        end
    end

    // Next-state logic. DRAIN finishes on the cycle of the final transfer so
    // that done follows the last write immediately. Every issued row is
    // eventually sent, so sent reaching num_rows implies FIFO and read
    // pipeline are both empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_rows != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (issued_q == num_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((sent_q == num_q) || (pop && (sent_inc == num_q))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration latch and progress counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_base_q <= '0;
            num_q      <= '0;
            ub_base_q  <= '0;
            relu_q     <= 1'b0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= acc_enb;
            if ((state_q == S_IDLE) && start) begin
                acc_base_q <= acc_base;
                num_q      <= num_rows;
                ub_base_q  <= ub_base;
                relu_q     <= relu_en;
                issued_q   <= '0;
                sent_q     <= '0;
            end else begin
                if (acc_enb) begin
                    issued_q <= issued_inc;
                end
                if (pop) begin
                    sent_q <= sent_inc;
                end
            end
        end
    end

    // Two-entry FIFO between the accumulator read port and the UB write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= push_row;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_writeback.sv
// tb_acc_writeback
// Directed table-driven bench for acc_writeback: a behavioural accumulator
// memory with one-cycle read latency feeds the DUT, and every write to the
// unified buffer is captured and compared against hand-derived expectations.
module tb_acc_writeback;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   acc_base;
    logic [4:0]   num_rows;
    logic [7:0]   ub_base;
    logic         relu_en;
    logic         busy;
    logic         done;
    logic         acc_enb;
    logic [3:0]   acc_addrb;
    logic [127:0] acc_doutb;
    logic         ub_wea;
    logic         ub_ready;
    logic [7:0]   ub_addra;
    logic [127:0] ub_dina;

    acc_writeback #(
        .DATA_NUM(16),
        .DATA_SIZE(8),
        .ACC_ADDR_WIDTH(4),
        .UB_ADDR_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .acc_base(acc_base),
        .num_rows(num_rows),
        .ub_base(ub_base),
        .relu_en(relu_en),
        .busy(busy),
        .done(done),
        .acc_enb(acc_enb),
        .acc_addrb(acc_addrb),
        .acc_doutb(acc_doutb),
        .ub_wea(ub_wea),
        .ub_ready(ub_ready),
        .ub_addra(ub_addra),
        .ub_dina(ub_dina)
    );

    typedef struct {
        logic [3:0] acc_base;
        logic [4:0] num_rows;
        logic [7:0] ub_base;
        logic       relu;
        int         mode;       // 0: ub_ready always 1, 1: ready every third cycle
        int         mid_start;  // pulse start during RUN
        int         exp_done;   // expected done cycle, -1 when not fixed
    } vec_t;

    vec_t         vecs [7];
    logic [127:0] acc_mem [16];
    logic [7:0]   wr_addr [$];
    logic [127:0] wr_data [$];
    logic [127:0] relu_row_exp;
    int           num_compared;
    int           num_mismatched;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator model: registered read, data valid the cycle after acc_enb.
    always @(posedge clk) begin
        if (acc_enb) acc_doutb <= acc_mem[acc_addrb];
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        num_compared++;
        if (act !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_at(input int mode, input int cyc);
        if (mode == 1) return (cyc % 3) == 0;
        return 1'b1;
    endfunction

    function automatic logic [127:0] exp_row(input logic [3:0] a, input logic relu);
        logic [127:0] v;
        v = acc_mem[a];
        for (int i = 0; i < 16; i++) begin
            if (relu && v[i*8+7]) v[i*8 +: 8] = 8'h00;
        end
        return v;
    endfunction

    // Runs one full drain starting in the current cycle (cycle 0) and checks
    // read addresses, write order/content, stall stability, occupancy and
    // completion timing. Leaves the bench in the first IDLE cycle afterwards.
    task automatic applyStimulus(input vec_t v);
        int cyc, reads, writes, first_w, last_w, done_c, throttled;
        logic prev_stall;
        logic [7:0] prev_addr;
        logic [127:0] prev_data;
        wr_addr.delete();
        wr_data.delete();
        reads = 0; writes = 0; first_w = -1; last_w = -1; done_c = -1;
        throttled = 0; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        acc_base = v.acc_base;
        num_rows = v.num_rows;
        ub_base  = v.ub_base;
        relu_en  = v.relu;
        start    = 1'b1;
        ub_ready = ready_at(v.mode, 0);
        cyc = 0;
        while (done_c < 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            // Config is free to change once latched.
            start    = (v.mid_start != 0) && (cyc == 2);
            acc_base = 4'(cyc * 7);
            num_rows = 5'(cyc);
            ub_base  = 8'(cyc * 13);
            relu_en  = cyc[0];
            ub_ready = ready_at(v.mode, cyc);
            @(negedge clk);
            if (acc_enb) begin
                checkOutput("rd_addr", acc_addrb, 4'(v.acc_base + reads));
                reads++;
            end
            if (busy && !acc_enb && reads < int'(v.num_rows)) throttled++;
            if (prev_stall) begin
                checkOutput("stall_wea", ub_wea, 1'b1);
                checkOutput("stall_addr", ub_addra, prev_addr);
                checkOutput("stall_data", ub_dina, prev_data);
            end
            if (ub_wea && ub_ready) begin
                wr_addr.push_back(ub_addra);
                wr_data.push_back(ub_dina);
                writes++;
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
            end
            checkOutput("occupancy_le2", (reads - writes) <= 2, 1'b1);
            prev_stall = ub_wea && !ub_ready;
            prev_addr  = ub_addra;
            prev_data  = ub_dina;
            if (done) begin
                done_c = cyc;
                checkOutput("busy_in_done", busy, 1'b0);
            end
        end
        checkOutput("done_seen", done_c >= 0, 1'b1);
        if (v.exp_done >= 0) checkOutput("done_cycle", done_c, v.exp_done);
        checkOutput("rows_read", reads, int'(v.num_rows));
        checkOutput("rows_written", writes, int'(v.num_rows));
        for (int k = 0; k < writes && k < int'(v.num_rows); k++) begin
            checkOutput("wr_addr", wr_addr[k], 8'(v.ub_base + k));
            checkOutput("wr_data", wr_data[k], exp_row(4'(v.acc_base + k), v.relu));
        end
        if (v.mode == 0 && v.num_rows != 0) begin
            checkOutput("first_wea_cycle", first_w, 3);
            checkOutput("last_wea_cycle", last_w, int'(v.num_rows) + 2);
        end
        if (v.num_rows == 0) checkOutput("no_write_n0", first_w, -1);
        if (v.mode == 1) checkOutput("enb_throttled", throttled > 0, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_done", done, 1'b0);
    endtask

    initial begin
        vec_t clean;
        num_compared   = 0;
        num_mismatched = 0;
        rst = 1'b1; start = 1'b0; acc_base = '0; num_rows = '0; ub_base = '0;
        relu_en = 1'b0; ub_ready = 1'b1; acc_doutb = '0;

        for (int r = 0; r < 16; r++)
            for (int i = 0; i < 16; i++)
                acc_mem[r][i*8 +: 8] = 8'(r * 16 + i);
        // Row 5: lanes cycle -128, 127, -1, 0.
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: acc_mem[5][i*8 +: 8] = 8'h80;
                1: acc_mem[5][i*8 +: 8] = 8'h7F;
                2: acc_mem[5][i*8 +: 8] = 8'hFF;
                default: acc_mem[5][i*8 +: 8] = 8'h00;
            endcase
            relu_row_exp[i*8 +: 8] = (i % 4 == 1) ? 8'h7F : 8'h00;
        end

        //            base   n      ubb    relu mode mid done
        vecs[0] = '{4'd0,  5'd4,  8'h10, 1'b0, 0, 0, 7};
        vecs[1] = '{4'd5,  5'd1,  8'h20, 1'b1, 0, 0, 4};
        vecs[2] = '{4'd0,  5'd8,  8'h40, 1'b0, 1, 0, -1};
        vecs[3] = '{4'd14, 5'd4,  8'hFE, 1'b0, 0, 0, 7};
        vecs[4] = '{4'd3,  5'd0,  8'h55, 1'b0, 0, 0, 1};
        vecs[5] = '{4'd0,  5'd16, 8'h80, 1'b1, 0, 0, 19};
        vecs[6] = '{4'd2,  5'd4,  8'h30, 1'b0, 0, 1, 7};

        #3;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_enb", acc_enb, 1'b0);
        checkOutput("rst_wea", ub_wea, 1'b0);
        checkOutput("rst_addrb", acc_addrb, 4'h0);
        checkOutput("rst_addra", ub_addra, 8'h00);
        checkOutput("rst_dina", ub_dina, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) begin
            applyStimulus(vecs[t]);
            if (t == 1) checkOutput("relu_lanes", wr_data[0], relu_row_exp);
        end

        // Reset in cycle 4 of a 10-row drain.
        acc_base = 4'd0; num_rows = 5'd10; ub_base = 8'h00; relu_en = 1'b0;
        ub_ready = 1'b1; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_enb", acc_enb, 1'b0);
        checkOutput("midrst_wea", ub_wea, 1'b0);
        checkOutput("midrst_addrb", acc_addrb, 4'h0);
        checkOutput("midrst_addra", ub_addra, 8'h00);
        checkOutput("midrst_dina", ub_dina, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("post_rst_no_wea", ub_wea, 1'b0);
            @(posedge clk); #1;
        end
        clean = '{4'd0, 5'd10, 8'h60, 1'b0, 0, 0, 13};
        applyStimulus(clean);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
